// File: rtl/alu_checker.sv
// alu_checker: compares an ALU's F/CO against a reference model over a run of NVEC vectors.
// Build with ALU_CHECKER_FIRSTFAIL_EN defined to capture the first failing vector in ff_idx/ff_f.
module alu_checker #(
  parameter int LAT  = 1,
  parameter int NVEC = 8
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic [7:0] R,
  input  logic [7:0] S,
  input  logic       CI,
  input  logic [1:0] ALB_MI,
  input  logic [7:0] F,
  input  logic       CO,
  input  logic       check_en,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] vec_cnt,
  output logic [7:0] err_cnt,
  output logic [7:0] ff_idx,
  output logic [7:0] ff_f
);

  // state   | meaning
  // ST_IDLE | waiting for a check_en rising edge
  // ST_RUN  | sampling stimulus and comparing results
  // ST_DONE | NVEC compares made, results held until check_en drops
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] NVEC_C = 8'(NVEC);

  state_t     state_q, state_d;
  logic       en_q;
  logic [8:0] exp_in;
  logic [8:0] exp_q [LAT];
  logic [LAT-1:0] vld_q;
  logic       in_run, start, cmp_en, mismatch;
  logic [7:0] vec_cnt_q, vec_cnt_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;

  // Reference model: {CO,F} the ALU should produce for the current stimulus.
  always_comb begin
    exp_in = '0;
    unique case (ALB_MI)
      2'b00:   exp_in = {1'b0, R} + {1'b0, S} + {8'd0, CI};
      2'b01:   exp_in = {1'b0, R} + {1'b0, ~S} + {8'd0, CI};
      2'b10:   exp_in = {1'b0, R & S};
      default: exp_in = {1'b0, R | S};
    endcase
  end

  assign in_run   = (state_q == ST_RUN);
  assign start    = (state_q == ST_IDLE) && check_en && !en_q;
  assign cmp_en   = in_run && check_en && vld_q[LAT-1] && (vec_cnt_q < NVEC_C);
  assign mismatch = cmp_en && ({CO, F} != exp_q[LAT-1]);

  // Tags are cleared outside RUN so nothing from an earlier run can be compared.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) exp_q[i] <= '0;
    end else begin
      vld_q[0] <= in_run;
      exp_q[0] <= exp_in;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= in_run && vld_q[i-1];
        exp_q[i] <= exp_q[i-1];
      end
    end
  end

  // en_q resets high so a check_en held through reset is not seen as an edge.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      en_q    <= check_en;
    end
  end

  always_comb begin
    vec_cnt_d = vec_cnt_q;
    err_cnt_d = err_cnt_q;
    if (start) begin
      vec_cnt_d = '0;
      err_cnt_d = '0;
    end else if (cmp_en) begin
      vec_cnt_d = vec_cnt_q + 8'd1;
      if (mismatch && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (!check_en) state_d = ST_IDLE;
        else if (vec_cnt_d == NVEC_C) state_d = ST_DONE;
      end
      ST_DONE: if (!check_en) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (err_cnt_d == 8'd0);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      vec_cnt_q <= '0;
      err_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      vec_cnt_q <= vec_cnt_d;
      err_cnt_q <= err_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign vec_cnt = vec_cnt_q;
  assign err_cnt = err_cnt_q;

`ifdef ALU_CHECKER_FIRSTFAIL_EN
  logic       ff_seen_q;
  logic [7:0] ff_idx_q, ff_f_q;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      ff_seen_q <= 1'b0;
      ff_idx_q  <= '0;
      ff_f_q    <= '0;
    end else if (start) begin
      ff_seen_q <= 1'b0;
      ff_idx_q  <= '0;
      ff_f_q    <= '0;
    end else if (mismatch && !ff_seen_q) begin
      ff_seen_q <= 1'b1;
      ff_idx_q  <= vec_cnt_q;
      ff_f_q    <= F;
    end
  end

  assign ff_idx = ff_idx_q;
  assign ff_f   = ff_f_q;
`else
  assign ff_idx = '0;
  assign ff_f   = '0;
`endif

endmodule

// File: tb/tb_alu_checker.sv
// tb_alu_checker: the bench plays the ALU (results from a hand-computed vector table, delayed LAT
// cycles) for three checker instances: LAT=1/NVEC=8, LAT=3/NVEC=8 and LAT=1/NVEC=255.
module tb_alu_checker;

  typedef struct {
    logic [1:0] op;
    logic [7:0] r;
    logic [7:0] s;
    logic       ci;
    logic       inj;
    logic [7:0] exp_f;
    logic       exp_co;
  } vec_t;

  typedef struct {
    logic [7:0] vec;
    logic [7:0] err;
  } sb_t;

`ifdef ALU_CHECKER_FIRSTFAIL_EN
  localparam bit FF_EN = 1'b1;
`else
  localparam bit FF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic [7:0] r_i = '0, s_i = '0;
  logic       ci_i = 1'b0;
  logic [1:0] op_i = '0;
  logic       check_en_a = 1'b0, check_en_b = 1'b0, check_en_c = 1'b0;
  logic [9:0] a1 = '0, a3 = '0;
  logic [9:0] p1 [$];
  logic [9:0] p3 [$];
  sb_t        sb [$];
  vec_t       tbl [8];
  vec_t       idle;
  logic [7:0] vec_prev = '0;
  int         checks = 0;
  int         errors = 0;

  logic [7:0] f_a, f_b, f_c;
  logic       co_a, co_b, co_c;
  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b, busy_c, done_c, pass_c;
  logic [7:0] vec_a, err_a, ffi_a, fff_a;
  logic [7:0] vec_b, err_b, ffi_b, fff_b;
  logic [7:0] vec_c, err_c, ffi_c, fff_c;

  // inj flips F bit 0 for a and b; instance c always sees a wrong CO.
  assign f_a  = a1[7:0] ^ {7'd0, a1[9]};
  assign co_a = a1[8];
  assign f_b  = a3[7:0] ^ {7'd0, a3[9]};
  assign co_b = a3[8];
  assign f_c  = a1[7:0];
  assign co_c = ~a1[8];

  always #5 clk = ~clk;

  alu_checker #(.LAT(1), .NVEC(8)) u_a (
    .clk(clk), .resetb(resetb), .R(r_i), .S(s_i), .CI(ci_i), .ALB_MI(op_i),
    .F(f_a), .CO(co_a), .check_en(check_en_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .vec_cnt(vec_a), .err_cnt(err_a), .ff_idx(ffi_a), .ff_f(fff_a));

  alu_checker #(.LAT(3), .NVEC(8)) u_b (
    .clk(clk), .resetb(resetb), .R(r_i), .S(s_i), .CI(ci_i), .ALB_MI(op_i),
    .F(f_b), .CO(co_b), .check_en(check_en_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .vec_cnt(vec_b), .err_cnt(err_b), .ff_idx(ffi_b), .ff_f(fff_b));

  alu_checker #(.LAT(1), .NVEC(255)) u_c (
    .clk(clk), .resetb(resetb), .R(r_i), .S(s_i), .CI(ci_i), .ALB_MI(op_i),
    .F(f_c), .CO(co_c), .check_en(check_en_c), .busy(busy_c), .done(done_c),
    .pass(pass_c), .vec_cnt(vec_c), .err_cnt(err_c), .ff_idx(ffi_c), .ff_f(fff_c));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboard pop: each increment of u_a's vec_cnt must match the next expected entry.
  task automatic monitor();
    sb_t e;
    if (vec_a != vec_prev && vec_a != 8'd0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: actual vec_cnt %0d required no compare", vec_a);
      end else begin
        e = sb.pop_front();
        chk("sb_vec", vec_a, e.vec);
        chk("sb_err", err_a, e.err);
      end
    end
    vec_prev = vec_a;
  endtask

  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    r_i  = v.r;
    s_i  = v.s;
    ci_i = v.ci;
    op_i = v.op;
    p1.push_back({v.inj, v.exp_co, v.exp_f});
    p3.push_back({v.inj, v.exp_co, v.exp_f});
    if (p1.size() > 1) a1 = p1.pop_front();
    if (p3.size() > 3) a3 = p3.pop_front();
    @(negedge clk);
    monitor();
  endtask

  task automatic run_a(input logic [7:0] mask, input string tag);
    int         cum;
    int         found;
    logic [7:0] ffi_e, fff_e;
    vec_t       v;
    cum = 0; found = 0; ffi_e = '0; fff_e = '0;
    check_en_a = 1'b0;
    step(idle);
    step(idle);
    check_en_a = 1'b1;
    for (int k = 0; k < 8; k++) begin
      v = tbl[k];
      v.inj = mask[k];
      if (mask[k]) begin
        cum++;
        if (found == 0) begin
          found = 1;
          ffi_e = FF_EN ? 8'(k) : 8'd0;
          fff_e = FF_EN ? (tbl[k].exp_f ^ 8'h01) : 8'd0;
        end
      end
      sb.push_back('{vec: 8'(k + 1), err: 8'(cum)});
      step(v);
      if (k == 0) begin
        chk({tag, "_entry_busy"}, busy_a, 1);
        chk({tag, "_entry_vec"}, vec_a, 0);
      end
      if (k == 1) chk({tag, "_lat1_before"}, vec_a, 0);
      if (k == 2) chk({tag, "_lat1_first"}, vec_a, 1);
    end
    step(idle);
    step(idle);
    step(idle);
    chk({tag, "_done"}, done_a, 1);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_vec"}, vec_a, 8);
    chk({tag, "_err"}, err_a, cum);
    chk({tag, "_pass"}, pass_a, (cum == 0));
    chk({tag, "_ff_idx"}, ffi_a, ffi_e);
    chk({tag, "_ff_f"}, fff_a, fff_e);
    chk({tag, "_sb_left"}, sb.size(), 0);
    check_en_a = 1'b0;
    step(idle);
    chk({tag, "_idle_done"}, done_a, 0);
    chk({tag, "_idle_pass"}, pass_a, 0);
  endtask

  initial begin
    vec_t v;
    idle   = '{op: 2'b00, r: 8'h00, s: 8'h00, ci: 1'b0, inj: 1'b0, exp_f: 8'h00, exp_co: 1'b0};
    tbl[0] = '{op: 2'b00, r: 8'h55, s: 8'h33, ci: 1'b1, inj: 1'b0, exp_f: 8'h89, exp_co: 1'b0};
    tbl[1] = '{op: 2'b01, r: 8'hAA, s: 8'h0F, ci: 1'b0, inj: 1'b0, exp_f: 8'h9A, exp_co: 1'b1};
    tbl[2] = '{op: 2'b10, r: 8'h0F, s: 8'hF0, ci: 1'b0, inj: 1'b0, exp_f: 8'h00, exp_co: 1'b0};
    tbl[3] = '{op: 2'b11, r: 8'hFF, s: 8'h00, ci: 1'b0, inj: 1'b0, exp_f: 8'hFF, exp_co: 1'b0};
    tbl[4] = '{op: 2'b00, r: 8'hFF, s: 8'h01, ci: 1'b0, inj: 1'b0, exp_f: 8'h00, exp_co: 1'b1};
    tbl[5] = '{op: 2'b01, r: 8'h10, s: 8'h10, ci: 1'b1, inj: 1'b0, exp_f: 8'h00, exp_co: 1'b1};
    tbl[6] = '{op: 2'b10, r: 8'hF0, s: 8'hAA, ci: 1'b1, inj: 1'b0, exp_f: 8'hA0, exp_co: 1'b0};
    tbl[7] = '{op: 2'b01, r: 8'h00, s: 8'h01, ci: 1'b0, inj: 1'b0, exp_f: 8'hFE, exp_co: 1'b0};

    // Reset with check_en already high: outputs zero, and no run after release.
    check_en_a = 1'b1;
    #12;
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_vec", vec_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_ff", {ffi_a, fff_a}, 0);
    @(negedge clk);
    resetb = 1'b1;
    step(idle);
    step(idle);
    step(idle);
    chk("rst_hold_busy", busy_a, 0);
    chk("rst_hold_vec", vec_a, 0);

    run_a(8'h00, "clean");
    run_a(8'h01, "ff0");
    run_a(8'hA0, "ff5");

    // Abort after three compares, then restart.
    check_en_a = 1'b0;
    step(idle);
    step(idle);
    check_en_a = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) sb.push_back('{vec: 8'(k + 1), err: 8'd0});
      step(tbl[k]);
    end
    chk("abort_pre_vec", vec_a, 3);
    check_en_a = 1'b0;
    step(idle);
    step(idle);
    chk("abort_busy", busy_a, 0);
    chk("abort_done", done_a, 0);
    chk("abort_vec", vec_a, 3);
    chk("abort_sb_left", sb.size(), 0);
    check_en_a = 1'b1;
    step(idle);
    chk("restart_busy", busy_a, 1);
    chk("restart_vec", vec_a, 0);
    check_en_a = 1'b0;
    step(idle);
    step(idle);

    // Reset in the middle of a run that already has an error.
    check_en_a = 1'b1;
    v = tbl[0];
    v.inj = 1'b1;
    sb.push_back('{vec: 8'd1, err: 8'd1});
    step(v);
    sb.push_back('{vec: 8'd2, err: 8'd1});
    step(tbl[1]);
    step(tbl[2]);
    step(tbl[3]);
    chk("midrst_pre_busy", busy_a, 1);
    chk("midrst_pre_err", err_a, 1);
    resetb = 1'b0;
    #1;
    chk("midrst_busy", busy_a, 0);
    chk("midrst_vec", vec_a, 0);
    chk("midrst_err", err_a, 0);
    chk("midrst_ff", {ffi_a, fff_a}, 0);
    chk("midrst_done_pass", {done_a, pass_a}, 0);
    @(negedge clk);
    @(negedge clk);
    resetb = 1'b1;
    step(idle);
    step(idle);
    step(idle);
    chk("midrst_hold_busy", busy_a, 0);
    chk("midrst_hold_vec", vec_a, 0);
    chk("midrst_sb_left", sb.size(), 0);
    check_en_a = 1'b0;
    step(idle);

    // LAT=3: first compare three cycles after RUN entry.
    check_en_b = 1'b1;
    for (int k = 0; k < 8; k++) begin
      v = tbl[k];
      v.inj = (k == 1);
      step(v);
      if (k == 0) chk("lat3_entry_busy", busy_b, 1);
      if (k == 3) chk("lat3_before", vec_b, 0);
      if (k == 4) chk("lat3_first", vec_b, 1);
    end
    step(idle);
    step(idle);
    step(idle);
    step(idle);
    chk("lat3_done", done_b, 1);
    chk("lat3_vec", vec_b, 8);
    chk("lat3_err", err_b, 1);
    chk("lat3_pass", pass_b, 0);
    chk("lat3_ff_idx", ffi_b, FF_EN ? 8'd1 : 8'd0);
    chk("lat3_ff_f", fff_b, FF_EN ? 8'h9B : 8'd0);
    check_en_b = 1'b0;
    step(idle);

    // 255-vector run with CO wrong on every vector, then a restart.
    check_en_c = 1'b1;
    for (int k = 0; k < 255; k++) step(tbl[k % 8]);
    step(idle);
    step(idle);
    step(idle);
    chk("sat_err", err_c, 255);
    chk("sat_vec", vec_c, 255);
    chk("sat_done", done_c, 1);
    chk("sat_pass", pass_c, 0);
    chk("sat_ff_f", fff_c, FF_EN ? 8'h89 : 8'd0);
    check_en_c = 1'b0;
    step(idle);
    step(idle);
    check_en_c = 1'b1;
    step(tbl[0]);
    chk("sat_restart_err", err_c, 0);
    chk("sat_restart_vec", vec_c, 0);
    chk("sat_restart_busy", busy_c, 1);
    step(tbl[1]);
    step(tbl[2]);
    chk("sat_restart_err1", err_c, 1);
    chk("sat_restart_vec1", vec_c, 1);
    check_en_c = 1'b0;
    step(idle);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_checker.md
ALU_CHECKER -- requirements
Module: alu_checker

Interface
REQ-001 Parameter LAT, default 1: ALU result latency in clk cycles from stimulus to F/CO, legal 1..4.
REQ-002 Parameter NVEC, default 8: number of vectors compared per run, legal 1..255.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 resetb  input  1  asynchronous, active-low reset.
REQ-005 R  input  8  ALU operand A as driven to the ALU.
REQ-006 S  input  8  ALU operand B as driven to the ALU.
REQ-007 CI  input  1  ALU carry-in as driven to the ALU.
REQ-008 ALB_MI  input  2  ALU opcode as driven to the ALU.
REQ-009 F  input  8  ALU result under check.
REQ-010 CO  input  1  ALU carry-out under check.
REQ-011 check_en  input  1  level; run request.
REQ-012 busy  output  1  high in RUN.
REQ-013 done  output  1  high in DONE.
REQ-014 pass  output  1  done and err_cnt==0.
REQ-015 vec_cnt  output  8  vectors compared this run.
REQ-016 err_cnt  output  8  mismatches this run, saturating.
REQ-017 ff_idx  output  8  vec_cnt value at the first mismatch.
REQ-018 ff_f  output  8  observed F at the first mismatch.

Function
REQ-019 Expected model: opcode 00 -> {CO,F}=R+S+CI (9-bit); 01 -> {CO,F}=R+~S+CI (9-bit); 10 -> F=R&S, CO=0; 11 -> F=R|S, CO=0.
REQ-020 FSM states IDLE, RUN, DONE; IDLE->RUN on a check_en rising edge; RUN->DONE on the cycle vec_cnt reaches NVEC; DONE->IDLE when check_en is low; RUN->IDLE when check_en falls before NVEC is reached, with counts held.
REQ-021 Entering RUN clears vec_cnt, err_cnt, ff_idx, ff_f and the first-fail flag.
REQ-022 In RUN, the block samples R/S/CI/ALB_MI every cycle into a LAT-deep valid-tagged delay line; only samples taken in RUN are tagged valid.
REQ-023 A compare occurs in the cycle a valid tag exits the delay line: expected {CO,F} vs sampled F/CO from that same cycle.
REQ-024 Each compare increments vec_cnt; no compares after vec_cnt==NVEC; samples still in flight on RUN exit are discarded.
REQ-025 A mismatch increments err_cnt, saturating at 255.
REQ-026 On the first mismatch of a run, ff_idx takes the pre-increment vec_cnt and ff_f takes F; both hold until the next run.
REQ-027 The first compare occurs LAT cycles after the RUN entry cycle.
REQ-028 busy, done and pass are registered and decoded from state; pass is low outside DONE.

Reset
REQ-029 resetb low forces IDLE, clears the delay line tags and drives all outputs to 0, asynchronously; this applies mid-run.
REQ-030 The first run after reset release requires a fresh check_en rising edge; check_en held high through reset does not start a run.

Configuration
REQ-031 Macro ALU_CHECKER_FIRSTFAIL_EN defined: first-fail capture is as in REQ-026.
REQ-032 Macro ALU_CHECKER_FIRSTFAIL_EN undefined: no capture logic; ff_idx and ff_f are constant 0; all other behaviour is unchanged.

Verification
REQ-033 LAT=1: R=55,S=33,CI=1,op00 then F=89,CO=0 -> no error; then F=88 -> err_cnt=1, ff_idx=0, ff_f=88.
REQ-034 Op01: R=AA,S=0F,CI=0 expects F=9A,CO=1; op10: 0F&F0 expects F=00,CO=0; op11: FF|00 expects F=FF,CO=0; a correct model -> pass=1 after NVEC=8.
REQ-035 Inject a mismatch on every vector of a 255-vector run plus a restart -> err_cnt saturates at 255 and does not wrap; a restart clears it to 0.
REQ-036 Drop check_en after 3 compares -> IDLE, vec_cnt=3, done=0; raise it again -> counters clear and a new run starts.
REQ-037 Assert resetb low mid-RUN -> all outputs are 0 immediately; after release with check_en held high -> the block stays in IDLE.
REQ-038 LAT=3: the first compare occurs 3 cycles after RUN entry; built without ALU_CHECKER_FIRSTFAIL_EN, ff_idx and ff_f stay 0 after a mismatch.
